// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 5x5 convolution window sequencer.
package conv_pkg;

  localparam int IMG_W = 64;
  localparam int PAD   = 2;
  localparam int K     = 2*PAD + 1;
  localparam int DW    = 8;
  localparam int VW    = $clog2(IMG_W + 2*PAD);
  localparam int AW    = 2*$clog2(IMG_W);
  localparam int TAPS  = K*K;
  localparam int CW    = $clog2(IMG_W);
  localparam int KW    = $clog2(K);
  localparam int TW    = $clog2(TAPS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/conv_tap_counter.sv
// Nested kc / kr / out_col / out_row counters with running tap index and last flags.
module conv_tap_counter #(
  parameter int IMG_W = conv_pkg::IMG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    adv,
  output logic [conv_pkg::KW-1:0] kc,
  output logic [conv_pkg::KW-1:0] kr,
  output logic [conv_pkg::TW-1:0] tap_idx,
  output logic [conv_pkg::CW-1:0] col,
  output logic [conv_pkg::CW-1:0] row,
  output logic                    win_last,
  output logic                    scan_last
);
  import conv_pkg::*;

  logic kc_wrap, col_wrap, row_wrap;

  assign kc_wrap   = (kc == KW'(K-1));
  assign win_last  = kc_wrap && (kr == KW'(K-1));
  assign col_wrap  = (col == CW'(IMG_W-1));
  assign row_wrap  = (row == CW'(IMG_W-1));
  assign scan_last = win_last && col_wrap && row_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc      <= '0;
      kr      <= '0;
      tap_idx <= '0;
      col     <= '0;
      row     <= '0;
    end else if (clr) begin
      kc      <= '0;
      kr      <= '0;
      tap_idx <= '0;
      col     <= '0;
      row     <= '0;
    end else if (adv) begin
      if (!kc_wrap) begin
        kc      <= kc + KW'(1);
        tap_idx <= tap_idx + TW'(1);
      end else if (!win_last) begin
        kc      <= '0;
        kr      <= kr + KW'(1);
        tap_idx <= tap_idx + TW'(1);
      end else begin
        // window finished: move to the next output pixel
        kc      <= '0;
        kr      <= '0;
        tap_idx <= '0;
        if (!col_wrap) begin
          col <= col + CW'(1);
        end else begin
          col <= '0;
          row <= row_wrap ? '0 : row + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every 5x5 window of the image, reads each tap through the external MMU and
// streams it to the MAC with valid/ready backpressure.
//
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | memory read of the current tap
//   CAPT  | capture read data and tap tags
//   HOLD  | tap presented, waiting for tap_ready
//   DONE  | one-cycle completion pulse
module conv_window_sequencer #(
  parameter int IMG_W = conv_pkg::IMG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [conv_pkg::VW-1:0] virt_row,
  output logic [conv_pkg::VW-1:0] virt_col,
  input  logic [conv_pkg::AW-1:0] phys_addr,
  output logic                    mem_rd,
  output logic [conv_pkg::AW-1:0] mem_addr,
  input  logic [conv_pkg::DW-1:0] mem_q,
  output logic                    tap_valid,
  input  logic                    tap_ready,
  output logic [conv_pkg::DW-1:0] tap_data,
  output logic [conv_pkg::TW-1:0] tap_k,
  output logic                    tap_last,
  output logic [conv_pkg::CW-1:0] out_row,
  output logic [conv_pkg::CW-1:0] out_col
);
  import conv_pkg::*;

  state_t          state, state_nxt;
  logic [KW-1:0]   kc, kr;
  logic [TW-1:0]   tap_idx;
  logic            win_last, scan_last;
  logic            hs, clr, adv;

  assign hs  = (state == HOLD) && tap_ready;
  assign clr = (state == IDLE) && start;
  // the final handshake leaves the counters parked on the last pixel
  assign adv = hs && !scan_last;

  conv_tap_counter #(.IMG_W(IMG_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .adv       (adv),
    .kc        (kc),
    .kr        (kr),
    .tap_idx   (tap_idx),
    .col       (out_col),
    .row       (out_row),
    .win_last  (win_last),
    .scan_last (scan_last)
  );

  assign virt_row = VW'(out_row) + VW'(kr);
  assign virt_col = VW'(out_col) + VW'(kc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = HOLD;
      HOLD:    if (tap_ready) state_nxt = scan_last ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_rd    = (state == ISSUE);
    tap_valid = (state == HOLD);
    mem_addr  = mem_rd ? phys_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_data <= '0;
      tap_k    <= '0;
      tap_last <= 1'b0;
    end else if (state == CAPT) begin
      tap_data <= mem_q;
      tap_k    <= tap_idx;
      tap_last <= win_last;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer on an 8x8 image instance so a full scan
// (64 windows x 25 taps) stays short; MMU and pixel memory are modelled here.
module tb_conv_window_sequencer;

  localparam int BIMG = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, tap_ready;
  logic        busy, done, mem_rd, tap_valid, tap_last;
  logic [6:0]  virt_row, virt_col;
  logic [11:0] phys_addr, mem_addr;
  logic [7:0]  mem_q = 8'h00;
  logic [7:0]  tap_data;
  logic [4:0]  tap_k;
  logic [5:0]  out_row, out_col;

  int vec = 0, miss = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [11:0] last_addr = 12'h0;

  conv_window_sequencer #(.IMG_W(BIMG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .virt_row(virt_row), .virt_col(virt_col), .phys_addr(phys_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
    .tap_k(tap_k), .tap_last(tap_last), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mmu(input logic [6:0] vr, input logic [6:0] vc);
    int r, c;
    r = int'(vr) - 2;
    c = int'(vc) - 2;
    if (r < 0) r = 0;
    if (r > BIMG-1) r = BIMG-1;
    if (c < 0) c = 0;
    if (c > BIMG-1) c = BIMG-1;
    return 12'(r*BIMG + c);
  endfunction

  assign phys_addr = mmu(virt_row, virt_col);

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_q     <= mem_addr[7:0] ^ mem_addr[11:4];
      rd_cnt    <= rd_cnt + 1;
      last_addr <= mem_addr;
    end
    if (tap_valid && tap_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tap(input int r, input int c, input int k, input int budget);
    int n = 0;
    while (!(tap_valid && out_row == 6'(r) && out_col == 6'(c) && tap_k == 5'(k)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_%0d_%0d_%0d", r, c, k), 32'(n < budget), 32'd1);
  endtask

  task automatic chk_tap(input string tag, input int vr, input int vc, input int addr,
                         input int data, input int last);
    chk({tag, "_vrow"}, 32'(virt_row), 32'(vr));
    chk({tag, "_vcol"}, 32'(virt_col), 32'(vc));
    chk({tag, "_addr"}, 32'(last_addr), 32'(addr));
    chk({tag, "_data"}, 32'(tap_data), 32'(data));
    chk({tag, "_last"}, 32'(tap_last), 32'(last));
  endtask

  initial begin
    int n, base;
    rst_n = 1'b0; start = 1'b0; tap_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(tap_valid), 0);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_vrow", 32'(virt_row), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // first window, with a 5-cycle stall on tap 7
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    wait_tap(0, 0, 0, 20);
    chk_tap("w0_t0", 0, 0, 0, 8'h00, 0);
    wait_tap(0, 0, 7, 40);
    tap_ready = 1'b0;
    chk("stall_rd_cnt", 32'(rd_cnt), 8);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(tap_valid), 1);
      chk("stall_k", 32'(tap_k), 7);
      chk("stall_data", 32'(tap_data), 8'h00);
      chk("stall_rd", 32'(mem_rd), 0);
    end
    chk("stall_hs", 32'(hs_cnt), 7);
    tap_ready = 1'b1;
    @(negedge clk);
    chk("resume_rd", 32'(mem_rd), 1);
    chk("resume_vrow", 32'(virt_row), 1);
    chk("resume_vcol", 32'(virt_col), 3);
    wait_tap(0, 0, 8, 20);
    chk("resume_rd_cnt", 32'(rd_cnt), 9);
    wait_tap(0, 0, 12, 40);
    chk_tap("w0_t12", 2, 2, 0, 8'h00, 0);
    wait_tap(0, 0, 24, 60);
    chk_tap("w0_t24", 4, 4, 18, 8'h13, 1);

    wait_tap(3, 5, 13, 3000);
    chk_tap("w29_t13", 5, 8, 30, 8'h1F, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    wait_tap(7, 7, 0, 6000);
    chk_tap("wlast_t0", 7, 7, 45, 8'h2F, 0);
    wait_tap(7, 7, 24, 200);
    chk_tap("wlast_t24", 11, 11, 63, 8'h3C, 1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_low", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("hold_row", 32'(out_row), 7);
    chk("hold_col", 32'(out_col), 7);
    repeat (3) @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 0);
    chk("hs_total", 32'(hs_cnt), 1600);
    chk("rd_total", 32'(rd_cnt), 1600);
    chk("done_total", 32'(done_cnt), 1);

    // reset in the middle of a second scan
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = hs_cnt;
    n = 0;
    while (hs_cnt - base < 500 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_hs500", 32'(n < 3000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(tap_valid), 0);
    chk("arst_data", 32'(tap_data), 0);
    chk("arst_k", 32'(tap_k), 0);
    chk("arst_row", 32'(out_row), 0);
    chk("arst_col", 32'(out_col), 0);
    chk("arst_vcol", 32'(virt_col), 0);
    chk("arst_rd", 32'(mem_rd), 0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 1);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tap(0, 0, 0, 20);
    chk_tap("restart_t0", 0, 0, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Sequences 5x5 convolution-window fetches over a 64x64 image stored row-major in a 4096-word pixel memory.
- For each output pixel it walks the 25 kernel taps in padded (68x68) virtual coordinates.
- It drives those coordinates into the team's MMU, which returns the clamped physical address. It then reads pixel memory and streams the taps to the downstream MAC with valid/ready backpressure.

Parameters:
- IMG_W, 64, image width and height in pixels (square image).
- PAD, 2, replicate-padding border; must match the MMU.
- K, 5, kernel size; K = 2*PAD+1.
- DW, 8, pixel data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a full-image scan when idle
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final tap handshake
- virt_row  out  7  padded row to MMU, equal to out_row + kr
- virt_col  out  7  padded column to MMU, equal to out_col + kc
- phys_addr  in  12  MMU result, combinational from virt_row/virt_col
- mem_rd  out  1  pixel-memory read strobe
- mem_addr  out  12  read address, equal to phys_addr while mem_rd is high
- mem_q  in  DW  read data, valid exactly 1 cycle after mem_rd
- tap_valid  out  1  tap_data, tap_k and tap_last are valid
- tap_ready  in  1  downstream accepts the tap
- tap_data  out  DW  pixel value of the current tap
- tap_k  out  5  tap index kr*K+kc, range 0..24
- tap_last  out  1  high with tap_k=24, marking the last tap of the window
- out_row  out  6  current output pixel row
- out_col  out  6  current output pixel column

Behaviour:
- Reset: rst_n low clears all outputs and counters to 0 immediately; state goes to IDLE. Reset mid-scan abandons the scan with no done pulse.
- Counters nest as follows, with the innermost listed first:
  - kc 0..K-1 (fastest)
  - kr 0..K-1
  - out_col 0..IMG_W-1
  - out_row 0..IMG_W-1 (slowest)
- virt_row/virt_col are combinational from the counters; width is $clog2(IMG_W+2*PAD)=7. No overflow: the maximum value is 63+4=67.
- FSM states:
  - IDLE: busy=0. On start, clear counters and go to ISSUE.
  - ISSUE: mem_rd=1, mem_addr=phys_addr; go to CAPT.
  - CAPT: register mem_q into tap_data; register tap_k and tap_last; set tap_valid=1; go to HOLD.
  - HOLD: tap_valid=1 with all tap outputs stable until tap_ready.
    - On handshake: clear tap_valid and advance the counters.
    - If the handshake was the last tap (out_row=out_col=IMG_W-1, tap_k=24), go to DONE. Otherwise go to ISSUE.
  - DONE: done=1 for one cycle, busy=0 next cycle; go to IDLE.
- Counters stay frozen in ISSUE, CAPT and HOLD; they change only on the HOLD handshake. The same virtual coordinate is therefore never read twice.
- Each tap takes at least 3 cycles (ISSUE, CAPT, HOLD with tap_ready=1). A full image is 4096*25 = 102400 taps.
- mem_rd is high only in ISSUE: exactly one read per tap, and none while stalled.
- start is ignored outside IDLE. start in the same cycle as DONE is also ignored.
- out_row/out_col hold the last pixel's values after DONE until the next start.

Decomposition:
- Shared package (conv_pkg) holds:
  - IMG_W, PAD, K
  - VW = $clog2(IMG_W+2*PAD)
  - AW = 2*$clog2(IMG_W)
  - TAPS = K*K
  - the FSM state enum (IDLE, ISSUE, CAPT, HOLD, DONE)
- One natural sub-module: conv_tap_counter, the 4-level nested counter with its last/wrap flags.
- The MMU stays external; the top level wires virt_row/virt_col to it and phys_addr back.

Test Plan:
- Bench setup: MMU and a memory model with mem[a] = a[7:0] XOR a[11:4]; tap_ready held at 1.
- Start, first window: tap_k=0 has virt (0,0) and mem_addr 0; tap_k=12 has virt (2,2) and mem_addr 0; tap_k=24 has virt (4,4) and mem_addr 130 with tap_last=1. tap_data matches the model at each.
- Last window (out_row=out_col=63): tap_k=24 has virt (67,67) and mem_addr 4095; tap_k=0 has virt (63,63) and mem_addr 61*64+61=3965. done pulses exactly 1 cycle after the final handshake, then busy=0.
- Backpressure: hold tap_ready=0 for 5 cycles at window (0,0), tap_k=7 -> tap_valid, tap_data and tap_k stay stable; mem_rd stays 0 for the stall; the next mem_rd is for tap_k=8.
- Full run: count handshakes = 102400 and mem_rd pulses = 102400; done asserts exactly once. Pulse start mid-scan -> no effect.
- Reset mid-scan: assert rst_n low at tap 5000 -> all outputs go to 0 asynchronously with no done. A subsequent start restarts at out_row=out_col=0, tap_k=0.
